// File: rtl/uart_packet_rx_pkg.sv
// Shared definitions for the UART packet receiver: FSM encoding, sync marker,
// frame-format constants and the inter-byte timeout helper.
// Latency: n/a. Backpressure: n/a.
package uart_packet_rx_pkg;

    typedef enum logic [2:0] {
        HUNT    = 3'd0,
        LEN     = 3'd1,
        PAYLOAD = 3'd2,
        CSUM    = 3'd3,
        DRAIN   = 3'd4
    } state_t;

    localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;
    localparam int unsigned MIN_LEN       = 1;
    localparam int unsigned MAX_LEN_LIMIT = 255;
    // One byte on the line is start + 8 data + stop.
    localparam int unsigned BITS_PER_BYTE = 10;

    function automatic logic [31:0] to_cycles(input int unsigned clk_hz,
                                              input int unsigned baud,
                                              input int unsigned nbytes);
        return 32'((clk_hz / baud) * BITS_PER_BYTE * nbytes);
    endfunction

endpackage

// File: rtl/uart_packet_rx_if.sv
// Byte-in / packet-out bundle of the UART packet receiver, plus status pulses.
// Latency: n/a (wires only).
// Backpressure: m_ready stalls the packet stream; the rx side has none.
interface uart_packet_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       m_ready;
    logic       frame_ok;
    logic       csum_err;
    logic       len_err;
    logic       timeout_err;
    logic       overrun;

    // Receiver side: consumes bytes, produces the packet stream and pulses.
    modport master (
        input  rx_data, rx_valid, m_ready,
        output m_data, m_valid, m_last,
        output frame_ok, csum_err, len_err, timeout_err, overrun
    );

    // Environment side: feeds bytes, sinks the packet stream.
    modport slave (
        output rx_data, rx_valid, m_ready,
        input  m_data, m_valid, m_last,
        input  frame_ok, csum_err, len_err, timeout_err, overrun
    );
endinterface

// File: rtl/uart_packet_rx_buf.sv
// Payload store: DEPTH x 8 register array, one write port, one registered read port.
// Latency: read data appears the cycle after rd_en.
// Backpressure: none; rd_data holds while rd_en is low. Storage is not reset.
module uart_packet_rx_buf #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/uart_packet_rx.sv
// Frames a UART byte stream (SYNC, LEN, payload, CSUM), checks it and replays good payloads.
// Latency: frame_ok the cycle after CSUM; first m_valid one cycle later; 1 byte/cycle after.
// Backpressure: m_ready stalls the replay; bytes arriving while replaying are dropped (overrun).
// Ports: clk, reset (async, active high); bus.rx_data/rx_valid in; bus.m_data/m_valid/
//        m_last out with bus.m_ready in; bus.frame_ok/csum_err/len_err/timeout_err/overrun pulses.
module uart_packet_rx
    import uart_packet_rx_pkg::*;
#(
    parameter int unsigned INPUT_CLK     = 100_000_000,
    parameter int unsigned BAUD_RATE     = 115200,
    parameter int unsigned MAX_LEN       = 16,
    parameter logic [7:0]  SYNC_BYTE     = SYNC_BYTE_DEF,
    parameter int unsigned TIMEOUT_BYTES = 4
) (
    input logic             clk,
    input logic             reset,
    uart_packet_rx_if.master bus
);

    localparam int unsigned IDX_W     = $clog2(MAX_LEN + 1);
    localparam int unsigned BUF_AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [31:0] TO_CYCLES = to_cycles(INPUT_CLK, BAUD_RATE, TIMEOUT_BYTES);
    localparam logic [7:0]  MAX_LEN_B = 8'((MAX_LEN > MAX_LEN_LIMIT) ? MAX_LEN_LIMIT : MAX_LEN);
    localparam logic [7:0]  MIN_LEN_B = 8'(MIN_LEN);

    state_t            state, state_nxt;
    logic              rx_valid_d;
    logic              byte_stb;
    logic [7:0]        len;
    logic [7:0]        sum;
    logic [7:0]        sum_fin;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  rd_idx;
    logic [31:0]       to_cnt;
    logic              to_active;
    logic              to_hit;
    logic              m_valid_q, m_valid_nxt;
    logic              hs;
    logic              last_byte;
    logic              frame_ok_q, csum_err_q, len_err_q, timeout_err_q, overrun_q;
    logic              frame_ok_nxt, csum_err_nxt, len_err_nxt, timeout_err_nxt, overrun_nxt;
    logic              wr_en;
    logic              rd_en;
    logic [BUF_AW-1:0] rd_addr;
    logic [7:0]        rd_data;

    // rx_valid is a level; only its rising edge carries a new byte.
    assign byte_stb  = bus.rx_valid & ~rx_valid_d;
    assign sum_fin   = sum + bus.rx_data;
    assign to_active = state inside {LEN, PAYLOAD, CSUM};
    // Fires in the cycle where the counter would reach TO_CYCLES.
    assign to_hit    = to_active && (to_cnt == TO_CYCLES - 32'd1);
    assign hs        = m_valid_q & bus.m_ready;
    assign last_byte = (8'(rd_idx) == len - 8'd1);

    always_comb begin
        state_nxt       = state;
        frame_ok_nxt    = 1'b0;
        csum_err_nxt    = 1'b0;
        len_err_nxt     = 1'b0;
        timeout_err_nxt = 1'b0;
        overrun_nxt     = 1'b0;
        m_valid_nxt     = 1'b0;
        case (state)
            HUNT: begin
                if (byte_stb && bus.rx_data == SYNC_BYTE) begin
                    state_nxt = LEN;
                end
            end
            LEN: begin
                if (byte_stb) begin
                    if (bus.rx_data < MIN_LEN_B || bus.rx_data > MAX_LEN_B) begin
                        len_err_nxt = 1'b1;
                        state_nxt   = HUNT;
                    end else begin
                        state_nxt = PAYLOAD;
                    end
                end else if (to_hit) begin
                    timeout_err_nxt = 1'b1;
                    state_nxt       = HUNT;
                end
            end
            PAYLOAD: begin
                // A SYNC value here is just data; no resync mid-frame.
                if (byte_stb) begin
                    if (8'(idx) == len - 8'd1) begin
                        state_nxt = CSUM;
                    end
                end else if (to_hit) begin
                    timeout_err_nxt = 1'b1;
                    state_nxt       = HUNT;
                end
            end
            CSUM: begin
                if (byte_stb) begin
                    if (sum_fin == 8'h00) begin
                        frame_ok_nxt = 1'b1;
                        state_nxt    = DRAIN;
                    end else begin
                        csum_err_nxt = 1'b1;
                        state_nxt    = HUNT;
                    end
                end else if (to_hit) begin
                    timeout_err_nxt = 1'b1;
                    state_nxt       = HUNT;
                end
            end
            DRAIN: begin
                // First DRAIN cycle waits for the buffer read of byte 0.
                overrun_nxt = byte_stb;
                m_valid_nxt = 1'b1;
                if (hs && last_byte) begin
                    m_valid_nxt = 1'b0;
                    state_nxt   = HUNT;
                end
            end
            default: state_nxt = HUNT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= HUNT;
            rx_valid_d    <= 1'b0;
            len           <= '0;
            sum           <= '0;
            idx           <= '0;
            rd_idx        <= '0;
            to_cnt        <= '0;
            m_valid_q     <= 1'b0;
            frame_ok_q    <= 1'b0;
            csum_err_q    <= 1'b0;
            len_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state         <= state_nxt;
            rx_valid_d    <= bus.rx_valid;
            m_valid_q     <= m_valid_nxt;
            frame_ok_q    <= frame_ok_nxt;
            csum_err_q    <= csum_err_nxt;
            len_err_q     <= len_err_nxt;
            timeout_err_q <= timeout_err_nxt;
            overrun_q     <= overrun_nxt;

            // A byte in the hit cycle wins: the strobe clears the counter.
            if (!to_active || byte_stb) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 32'd1;
            end

            case (state)
                LEN: begin
                    if (byte_stb) begin
                        len <= bus.rx_data;
                        sum <= bus.rx_data;
                        idx <= '0;
                    end
                end
                PAYLOAD: begin
                    if (byte_stb) begin
                        sum <= sum_fin;
                        idx <= idx + IDX_W'(1);
                    end
                end
                CSUM: begin
                    if (byte_stb) begin
                        rd_idx <= '0;
                    end
                end
                DRAIN: begin
                    if (hs) begin
                        rd_idx <= rd_idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Byte 0 is fetched while the checksum is accepted; each handshake fetches
    // the next one, so the read register always holds the byte on offer.
    assign wr_en   = (state == PAYLOAD) && byte_stb;
    assign rd_en   = ((state == CSUM) && byte_stb && sum_fin == 8'h00) || (hs && !last_byte);
    assign rd_addr = (state == CSUM) ? '0 : rd_idx[BUF_AW-1:0] + BUF_AW'(1);

    uart_packet_rx_buf #(
        .DEPTH (MAX_LEN),
        .AW    (BUF_AW)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (idx[BUF_AW-1:0]),
        .wr_data (bus.rx_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign bus.m_data      = rd_data;
    assign bus.m_valid     = m_valid_q;
    assign bus.m_last      = m_valid_q & last_byte;
    assign bus.frame_ok    = frame_ok_q;
    assign bus.csum_err    = csum_err_q;
    assign bus.len_err     = len_err_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.overrun     = overrun_q;

endmodule
